// File: rtl/tq_pkg.sv
// Shared constants for the two-pass transform control block: FSM encoding,
// transform size codes and the transpose-buffer index width.
package tq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROW   = 3'd1,
        ST_COL   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } tq_state_e;

    localparam logic [1:0] TQ_SZ4  = 2'd0;
    localparam logic [1:0] TQ_SZ8  = 2'd1;
    localparam logic [1:0] TQ_SZ16 = 2'd2;
    localparam logic [1:0] TQ_SZ32 = 2'd3;

    localparam int TQ_CNT_W = 5;

    // Index of the last row/column of an N = 4 << sz block.
    function automatic logic [TQ_CNT_W-1:0] tq_last_idx(input logic [1:0] sz);
        logic [5:0] n;
        logic [5:0] m;
        n = 6'd4 << sz;
        m = n - 6'd1;
        return m[TQ_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/tq_pass_ctl_if.sv
// Handshake/control bundle between the transform datapath and tq_pass_ctl.
// The i_tskip member exists only when TQ_PASS_TSKIP_EN is defined.
interface tq_pass_ctl_if;
    import tq_pkg::*;

    logic                i_start;
    logic [1:0]          i_size;
    logic                i_row_valid;
    logic                i_col_ready;
    logic                i_col_valid;
`ifdef TQ_PASS_TSKIP_EN
    logic                i_tskip;
`endif
    logic                o_row;
    logic                o_wr_en;
    logic [TQ_CNT_W-1:0] o_wr_addr;
    logic                o_rd_en;
    logic [TQ_CNT_W-1:0] o_rd_addr;
    logic                o_busy;
    logic                o_done;

    modport slave (
        input  i_start, i_size, i_row_valid, i_col_ready, i_col_valid,
`ifdef TQ_PASS_TSKIP_EN
        input  i_tskip,
`endif
        output o_row, o_wr_en, o_wr_addr, o_rd_en, o_rd_addr, o_busy, o_done
    );

    modport master (
        output i_start, i_size, i_row_valid, i_col_ready, i_col_valid,
`ifdef TQ_PASS_TSKIP_EN
        output i_tskip,
`endif
        input  o_row, o_wr_en, o_wr_addr, o_rd_en, o_rd_addr, o_busy, o_done
    );

endinterface

// File: rtl/tq_pass_ctl.sv
// Row/column pass sequencer for a 2D transform with an external transpose buffer.
// Optional transform-skip (4x4 only, row pass only) when TQ_PASS_TSKIP_EN is defined.
module tq_pass_ctl
    import tq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    tq_pass_ctl_if.slave  bus
);

    tq_state_e           state_q, state_d;
    logic [1:0]          size_q;
    logic                tskip_q;
    logic                row_q;
    logic [TQ_CNT_W-1:0] row_cnt_q, rd_cnt_q, out_cnt_q, last_idx;
    logic                start_ok, row_beat, rd_beat, out_beat;
    logic                row_last, rd_last, out_last;

    assign last_idx = tq_last_idx(size_q);
    assign start_ok = bus.i_start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign row_beat = (state_q == ST_ROW) && bus.i_row_valid;
    assign rd_beat  = (state_q == ST_COL) && bus.i_col_ready;
    assign out_beat = (state_q == ST_COL || state_q == ST_DRAIN) && bus.i_col_valid;
    assign row_last = row_beat && (row_cnt_q == last_idx);
    assign rd_last  = rd_beat  && (rd_cnt_q  == last_idx);
    assign out_last = out_beat && (out_cnt_q == last_idx);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_ROW;
            ST_ROW:   if (row_last) state_d = tskip_q ? ST_DONE : ST_COL;
            // Last read and last output beat can coincide when the column datapath is fast.
            ST_COL:   if (rd_last)  state_d = out_last ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (out_last) state_d = ST_DONE;
            ST_DONE:  state_d = start_ok ? ST_ROW : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q    <= TQ_SZ4;
            row_cnt_q <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            row_q     <= 1'b0;
        end else if (start_ok) begin
            size_q    <= bus.i_size;
            row_cnt_q <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            row_q     <= 1'b0;
        end else begin
            if (row_beat) row_cnt_q <= row_cnt_q + 1'b1;
            if (rd_beat)  rd_cnt_q  <= rd_cnt_q + 1'b1;
            if (out_beat) out_cnt_q <= out_cnt_q + 1'b1;
            if (row_last && !tskip_q) row_q <= 1'b1;
        end
    end

`ifdef TQ_PASS_TSKIP_EN
    // Skip only applies to 4x4; larger sizes always run both passes.
    always_ff @(posedge clk) begin
        if (rst)           tskip_q <= 1'b0;
        else if (start_ok) tskip_q <= bus.i_tskip && (bus.i_size == TQ_SZ4);
    end
`else
    assign tskip_q = 1'b0;
`endif

    assign bus.o_row     = row_q;
    assign bus.o_wr_en   = row_beat;
    assign bus.o_wr_addr = row_cnt_q;
    assign bus.o_rd_en   = rd_beat;
    assign bus.o_rd_addr = rd_cnt_q;
    assign bus.o_busy    = (state_q == ST_ROW) || (state_q == ST_COL) || (state_q == ST_DRAIN);
    assign bus.o_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_tq_pass_ctl.sv
// Scoreboard bench for tq_pass_ctl: expected write/read addresses and done pulses
// are queued as stimulus is driven and retired by a negedge monitor.
module tb_tq_pass_ctl;
    import tq_pkg::*;

    logic clk;
    logic rst;
    tq_pass_ctl_if bus ();

    tq_pass_ctl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int rd_pulses = 0;
    int exp_wr[$];
    int exp_rd[$];
    int exp_done[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_wr_en) begin
            if (exp_wr.size() == 0) check("wr_unexpected", bus.o_wr_en, 0);
            else                    check("wr_addr", bus.o_wr_addr, exp_wr.pop_front());
        end
        if (bus.o_rd_en) begin
            rd_pulses++;
            if (exp_rd.size() == 0) check("rd_unexpected", bus.o_rd_en, 0);
            else                    check("rd_addr", bus.o_rd_addr, exp_rd.pop_front());
        end
        if (bus.o_done) begin
            if (exp_done.size() == 0) check("done_unexpected", bus.o_done, 0);
            else                      check("done", bus.o_done, exp_done.pop_front());
        end
    end

    // tog: ready every other cycle; lat0: column beat same cycle as read;
    // mid: stray start during COL; b2b: start in the current (DONE) cycle.
    task automatic run_block(input logic [1:0] sz, input bit tog, input bit lat0,
                             input bit mid, input bit tsk, input bit b2b);
        int  n, reads, beats, cyc;
        bit  pend, rdy, v, tsk_eff;
        n = 4 << sz;
        tsk_eff = 1'b0;
`ifdef TQ_PASS_TSKIP_EN
        tsk_eff = tsk && (sz == 2'd0);
        bus.i_tskip = tsk;
`endif
        if (!b2b) begin
            @(posedge clk); #1;
        end
        bus.i_start = 1'b1;
        bus.i_size  = sz;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("start_state", dut.state_q, ST_ROW);
        check("start_row", bus.o_row, 0);
        check("start_busy", bus.o_busy, 1);
        for (int r = 0; r < n; r++) begin
            bus.i_row_valid = 1'b1;
            exp_wr.push_back(r);
            if (r == n - 1 && tsk_eff) exp_done.push_back(1);
            @(posedge clk); #1;
        end
        bus.i_row_valid = 1'b0;
        if (tsk_eff) begin
            check("tskip_state", dut.state_q, ST_DONE);
            check("tskip_row", bus.o_row, 0);
            return;
        end
        check("row_done_state", dut.state_q, ST_COL);
        check("row_rise", bus.o_row, 1);
        reads = 0; beats = 0; cyc = 0; pend = 1'b0;
        while (beats < n && cyc < 1000) begin
            rdy = (reads < n) && (!tog || cyc[0] == 1'b0);
            v   = lat0 ? rdy : pend;
            bus.i_col_ready = rdy;
            bus.i_col_valid = v;
            bus.i_start     = mid && (cyc == 2);
            if (rdy) begin
                exp_rd.push_back(reads);
                reads++;
            end
            if (v) beats++;
            if (beats == n) exp_done.push_back(1);
            pend = rdy;
            @(posedge clk); #1;
            if (rdy && reads == n)
                check("after_last_read", dut.state_q, lat0 ? ST_DONE : ST_DRAIN);
            cyc++;
        end
        bus.i_col_ready = 1'b0;
        bus.i_col_valid = 1'b0;
        bus.i_start     = 1'b0;
        check("col_timeout", (cyc < 1000) ? 1 : 0, 1);
        check("done_state", dut.state_q, ST_DONE);
        check("done_busy", bus.o_busy, 0);
        check("done_row_held", bus.o_row, 1);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_size = 2'd0;
        bus.i_row_valid = 1'b0; bus.i_col_ready = 1'b0; bus.i_col_valid = 1'b0;
`ifdef TQ_PASS_TSKIP_EN
        bus.i_tskip = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", dut.state_q, ST_IDLE);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_row", bus.o_row, 0);
        check("rst_wr_en", bus.o_wr_en, 0);
        check("rst_rd_en", bus.o_rd_en, 0);
        check("rst_wr_addr", bus.o_wr_addr, 0);
        check("rst_rd_addr", bus.o_rd_addr, 0);
        rst = 1'b0;

        // 8x8 started in the first cycle after reset release.
        run_block(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stray handshakes while idle are ignored.
        @(posedge clk); #1;
        bus.i_row_valid = 1'b1; bus.i_col_ready = 1'b1; bus.i_col_valid = 1'b1;
        @(negedge clk);
        check("stray_wr_en", bus.o_wr_en, 0);
        check("stray_rd_en", bus.o_rd_en, 0);
        @(posedge clk); #1;
        bus.i_row_valid = 1'b0; bus.i_col_ready = 1'b0; bus.i_col_valid = 1'b0;
        check("stray_state", dut.state_q, ST_IDLE);

        run_block(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        base = rd_pulses;
        run_block(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rd_pulses_32", rd_pulses - base, 32);

        run_block(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset on row beat 5 of a 16x16 block.
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_size = 2'd2;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int r = 0; r < 5; r++) begin
            bus.i_row_valid = 1'b1;
            exp_wr.push_back(r);
            if (r == 4) rst = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_state", dut.state_q, ST_IDLE);
        check("midrst_busy", bus.o_busy, 0);
        check("midrst_wr_addr", bus.o_wr_addr, 0);
        check("midrst_wr_en", bus.o_wr_en, 0);
        bus.i_row_valid = 1'b0;
        rst = 1'b0;
        run_block(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start issued in the DONE cycle.
        run_block(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef TQ_PASS_TSKIP_EN
        base = rd_pulses;
        run_block(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("tskip_no_reads", rd_pulses - base, 0);
        run_block(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.i_tskip = 1'b0;
`endif

        @(posedge clk); #1;
        @(negedge clk);
        check("wr_left", exp_wr.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        check("done_left", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
